// File: rtl/rs485_tx_sched.sv
// rs485_tx_sched: two-source round-robin transmit scheduler in front of
// uart_tx.
//
// The block also owns the RS485 driver-enable line. rs485_de rises with
// each grant. It stays high for DE_LEAD_CNT clocks before the pi_flag start
// strobe. After uart_tx drops work_en, it stays high for another
// DE_TAIL_CNT clocks.
//
// Optional build macro RS485_BURST_EN:
//   When defined, a request that is pending at the end of a frame is granted
//   in the same cycle that work_en is seen low. Its frame starts at once,
//   with no tail and no new lead, and rs485_de stays high across the
//   back-to-back frames.
//   When undefined, every frame goes through its own tail, then IDLE, then
//   a fresh lead.
module rs485_tx_sched #(
  parameter int unsigned DE_LEAD_CNT = 'd50,
  parameter int unsigned DE_TAIL_CNT = 'd5208
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack1,
  input  logic       work_en,
  output logic [7:0] pi_data,
  output logic       pi_flag,
  output logic       rs485_de,
  output logic       busy
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 16;

  // Terminal counts of the shared lead/tail counter.
  localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'(DE_LEAD_CNT - 1);
  localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(DE_TAIL_CNT - 1);

`ifdef RS485_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LEAD      = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    TAIL      = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               last_grant, last_grant_nxt;
  logic [DATA_W-1:0]  pi_data_nxt;
  logic               pi_flag_nxt, ack0_nxt, ack1_nxt, de_nxt, busy_nxt;

  logic               req_any;
  logic               gnt_sel;
  logic [DATA_W-1:0]  gnt_data;
  logic               burst_go;
  logic               grant_now;

  // Round-robin choice between the two requesters.
  // On contention, the requester that was not granted last time wins.
  always_comb begin
    req_any   = req0 | req1;
    gnt_sel   = (req0 & req1) ? ~last_grant : req1;
    gnt_data  = gnt_sel ? data1 : data0;
    burst_go  = BURST && (state == WAIT_DONE) && !work_en && req_any;
    grant_now = req_any && ((state == IDLE) || burst_go);
  end

  // State, counter, arbitration history and all registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      pi_data    <= '0;
      pi_flag    <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rs485_de   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_grant <= last_grant_nxt;
      pi_data    <= pi_data_nxt;
      pi_flag    <= pi_flag_nxt;
      ack0       <= ack0_nxt;
      ack1       <= ack1_nxt;
      rs485_de   <= de_nxt;
      busy       <= busy_nxt;
    end
  end

  // Next-state decode for the frame sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (req_any) state_nxt = LEAD;
      LEAD:      if (cnt == LEAD_LAST) state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (work_en) state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (!work_en) state_nxt = burst_go ? WAIT_BUSY : TAIL;
      end
      TAIL:      if (cnt == TAIL_LAST) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Next values of the counter and of the registered outputs.
  // pi_data is only reloaded on a grant, so it is held for the whole frame.
  always_comb begin
    cnt_nxt        = cnt;
    last_grant_nxt = last_grant;
    pi_data_nxt    = pi_data;
    pi_flag_nxt    = 1'b0;
    ack0_nxt       = 1'b0;
    ack1_nxt       = 1'b0;
    de_nxt         = rs485_de;

    if (grant_now) begin
      pi_data_nxt    = gnt_data;
      ack0_nxt       = ~gnt_sel;
      ack1_nxt       = gnt_sel;
      last_grant_nxt = gnt_sel;
      de_nxt         = 1'b1;
    end

    case (state)
      IDLE: begin
        if (req_any) cnt_nxt = '0;
      end
      LEAD: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LEAD_LAST) pi_flag_nxt = 1'b1;
      end
      WAIT_DONE: begin
        if (!work_en) begin
          if (burst_go) pi_flag_nxt = 1'b1;
          else          cnt_nxt     = '0;
        end
      end
      TAIL: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == TAIL_LAST) de_nxt = 1'b0;
      end
      default: ;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_rs485_tx_sched.sv
// Directed testbench for rs485_tx_sched with DE_LEAD_CNT=4, DE_TAIL_CNT=8.
// A small uart_tx stand-in raises work_en for a fixed frame after each
// pi_flag and logs the byte it was handed.
module tb_rs485_tx_sched;

  localparam int LEAD  = 4;
  localparam int TAILC = 8;
  localparam int FRAME = 6;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = 8'd0, data1 = 8'd0;
  logic       work_en = 1'b0;
  logic       ack0, ack1, pi_flag, rs485_de, busy;
  logic [7:0] pi_data;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] sent[$];
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         grant_log[$];
  int         de_falls;
  int         fcnt = 0;

  rs485_tx_sched #(.DE_LEAD_CNT(LEAD), .DE_TAIL_CNT(TAILC)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .work_en(work_en), .pi_data(pi_data), .pi_flag(pi_flag),
    .rs485_de(rs485_de), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  // uart_tx stand-in: busy for FRAME cycles after each start strobe.
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      work_en = 1'b0;
      fcnt = 0;
    end else if (pi_flag) begin
      sent.push_back(pi_data);
      work_en = 1'b1;
      fcnt = FRAME;
    end else if (fcnt > 0) begin
      fcnt = fcnt - 1;
      if (fcnt == 0) work_en = 1'b0;
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
    sys_rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_we(input logic lvl, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (work_en === lvl) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  // Serves both requesters from q0/q1 until everything is sent and idle.
  task automatic run_frames(input int max_cyc, output bit done);
    logic prev_de;
    done = 1'b0;
    de_falls = 0;
    prev_de = rs485_de;
    for (int c = 0; c < max_cyc; c++) begin
      tick();
      if (prev_de && !rs485_de) de_falls++;
      prev_de = rs485_de;
      if (ack0) begin
        grant_log.push_back(0);
        if (q0.size() > 0) data0 = q0.pop_front(); else req0 = 1'b0;
      end
      if (ack1) begin
        grant_log.push_back(1);
        if (q1.size() > 0) data1 = q1.pop_front(); else req1 = 1'b0;
      end
      if (!busy && !req0 && !req1) begin done = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    req0 = 1'b1; data0 = 8'hFF;
    tick();
    tests_run++; if (pi_data !== 8'd0) begin tests_failed++; $display("FAIL reset_pi_data got %h want 00", pi_data); end
    tests_run++; if (pi_flag !== 1'b0) begin tests_failed++; $display("FAIL reset_pi_flag got %b want 0", pi_flag); end
    tests_run++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin tests_failed++; $display("FAIL reset_ack got %b%b want 00", ack0, ack1); end
    tests_run++; if (rs485_de !== 1'b0) begin tests_failed++; $display("FAIL reset_de got %b want 0", rs485_de); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
    req0 = 1'b0;
    sys_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int n;
    bit ok;
    int base;
    do_reset();
    base = sent.size();
    req0 = 1'b1; data0 = 8'h55;
    tick();
    tests_run++; if (ack0 !== 1'b1 || rs485_de !== 1'b1 || busy !== 1'b1) begin tests_failed++; $display("FAIL single_grant ack0/de/busy got %b%b%b want 111", ack0, rs485_de, busy); end
    req0 = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick(); n++;
      if (n == 1) begin
        tests_run++; if (ack0 !== 1'b0) begin tests_failed++; $display("FAIL single_ack_width ack0 got %b want 0", ack0); end
      end
      if (pi_flag) break;
    end
    tests_run++; if (n !== LEAD) begin tests_failed++; $display("FAIL single_lead cycles got %0d want %0d", n, LEAD); end
    tests_run++; if (pi_data !== 8'h55) begin tests_failed++; $display("FAIL single_pi_data got %h want 55", pi_data); end
    tick();
    tests_run++; if (pi_flag !== 1'b0) begin tests_failed++; $display("FAIL single_flag_width got %b want 0", pi_flag); end
    wait_we(1'b1, ok);
    wait_we(1'b0, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL single_frame_timeout got 0 want 1"); end
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick(); n++;
      if (!rs485_de) break;
    end
    tests_run++; if (n !== TAILC) begin tests_failed++; $display("FAIL single_tail cycles got %0d want %0d", n, TAILC); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_end got %b want 0", busy); end
    tests_run++; if (sent.size() - base !== 1 || sent[base] !== 8'h55) begin tests_failed++; $display("FAIL single_sent got %0d bytes want 1 of 55", sent.size() - base); end
  endtask

  task automatic test_contention();
    bit done;
    int base;
    do_reset();
    base = sent.size();
    grant_log.delete(); q0.delete(); q1.delete();
    data0 = 8'hA1; data1 = 8'hB2;
    req0 = 1'b1; req1 = 1'b1;
    run_frames(400, done);
    tests_run++; if (!done) begin tests_failed++; $display("FAIL contention_timeout got 0 want 1"); end
    tests_run++; if (grant_log.size() !== 2 || grant_log[0] !== 0 || grant_log[1] !== 1) begin tests_failed++; $display("FAIL contention_order got %0d grants want 0,1", grant_log.size()); end
    tests_run++; if (sent.size() - base !== 2 || sent[base] !== 8'hA1 || sent[base+1] !== 8'hB2) begin tests_failed++; $display("FAIL contention_bytes got %0d bytes want A1,B2", sent.size() - base); end
`ifdef RS485_BURST_EN
    tests_run++; if (de_falls !== 1) begin tests_failed++; $display("FAIL contention_de_falls got %0d want 1", de_falls); end
`else
    tests_run++; if (de_falls !== 2) begin tests_failed++; $display("FAIL contention_de_falls got %0d want 2", de_falls); end
`endif
  endtask

  task automatic test_fairness();
    bit done;
    int base;
    logic [7:0] exp_b[4];
    exp_b[0] = 8'h11; exp_b[1] = 8'h21; exp_b[2] = 8'h12; exp_b[3] = 8'h22;
    do_reset();
    base = sent.size();
    grant_log.delete(); q0.delete(); q1.delete();
    q0.push_back(8'h12); q1.push_back(8'h22);
    data0 = 8'h11; data1 = 8'h21;
    req0 = 1'b1; req1 = 1'b1;
    run_frames(1000, done);
    tests_run++; if (!done || grant_log.size() !== 4) begin tests_failed++; $display("FAIL fairness_count got %0d grants want 4", grant_log.size()); end
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (grant_log[i] !== (i % 2)) begin tests_failed++; $display("FAIL fairness_grant%0d got %0d want %0d", i, grant_log[i], i % 2); end
      tests_run++; if (sent[base+i] !== exp_b[i]) begin tests_failed++; $display("FAIL fairness_byte%0d got %h want %h", i, sent[base+i], exp_b[i]); end
    end
  endtask

`ifndef RS485_BURST_EN
  task automatic test_late_req();
    bit ok, done;
    int early;
    int base;
    do_reset();
    base = sent.size();
    req0 = 1'b1; data0 = 8'h33;
    tick();
    req0 = 1'b0;
    wait_we(1'b1, ok);
    tick();
    req1 = 1'b1; data1 = 8'hB2;
    early = 0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (ack1) early++;
      if (!busy) begin ok = 1'b1; break; end
    end
    tests_run++; if (!ok || early !== 0) begin tests_failed++; $display("FAIL late_no_early_ack got %0d acks want 0", early); end
    tick();
    tests_run++; if (ack1 !== 1'b1 || pi_data !== 8'hB2) begin tests_failed++; $display("FAIL late_grant ack1=%b data=%h want 1 B2", ack1, pi_data); end
    req1 = 1'b0;
    grant_log.delete(); q0.delete(); q1.delete();
    run_frames(300, done);
    tests_run++; if (!done || sent.size() - base !== 2 || sent[base+1] !== 8'hB2) begin tests_failed++; $display("FAIL late_sent got %0d bytes want 33,B2", sent.size() - base); end
  endtask
`else
  task automatic test_burst();
    bit ok, done;
    int base;
    do_reset();
    base = sent.size();
    req0 = 1'b1; data0 = 8'hC3;
    tick();
    req0 = 1'b0;
    wait_we(1'b1, ok);
    req1 = 1'b1; data1 = 8'hD4;
    wait_we(1'b0, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL burst_timeout got 0 want 1"); end
    tests_run++; if (pi_flag !== 1'b1 || ack1 !== 1'b1) begin tests_failed++; $display("FAIL burst_same_cycle flag/ack1 got %b%b want 11", pi_flag, ack1); end
    tests_run++; if (pi_data !== 8'hD4 || rs485_de !== 1'b1) begin tests_failed++; $display("FAIL burst_data_de got %h/%b want D4/1", pi_data, rs485_de); end
    req1 = 1'b0;
    grant_log.delete(); q0.delete(); q1.delete();
    run_frames(300, done);
    tests_run++; if (!done || de_falls !== 1) begin tests_failed++; $display("FAIL burst_single_tail got %0d falls want 1", de_falls); end
    tests_run++; if (sent.size() - base !== 2 || sent[base+1] !== 8'hD4) begin tests_failed++; $display("FAIL burst_sent got %0d bytes want C3,D4", sent.size() - base); end
  endtask
`endif

  task automatic test_reset_mid_frame();
    bit ok, bad;
    do_reset();
    req0 = 1'b1; data0 = 8'h5A;
    tick();
    req0 = 1'b0;
    wait_we(1'b1, ok);
    tick();
    sys_rst_n = 1'b0;
    #1;
    tests_run++; if (rs485_de !== 1'b0 || pi_flag !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_outputs de/flag/busy got %b%b%b want 000", rs485_de, pi_flag, busy); end
    tests_run++; if (ack0 !== 1'b0 || ack1 !== 1'b0 || pi_data !== 8'd0) begin tests_failed++; $display("FAIL midrst_ack_data got %b%b/%h want 00/00", ack0, ack1, pi_data); end
    tick();
    sys_rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pi_flag || busy || rs485_de) bad = 1'b1;
    end
    tests_run++; if (bad !== 1'b0) begin tests_failed++; $display("FAIL midrst_stays_idle got activity want none"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
`ifndef RS485_BURST_EN
    test_late_req();
`else
    test_burst();
`endif
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
